// File: rtl/minmax_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minmax_pkg                                                           |
// | Shared types and constants for the burst min/max stream controller.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package minmax_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  // Fill bits replicated to the sample width when a burst starts
  localparam logic MIN_INIT = 1'b1;
  localparam logic MAX_INIT = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/minmax_cmp_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minmax_cmp_core                                                      |
// | Strict unsigned compare of one sample against running min/max.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module minmax_cmp_core
  import minmax_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] cur_min,
  input  logic [DATA_W-1:0] cur_max,
  output logic [DATA_W-1:0] nxt_min,
  output logic [DATA_W-1:0] nxt_max,
  output logic              upd_min,
  output logic              upd_max
);

  // Strict compares so ties keep the first occurrence
  assign upd_min = (d < cur_min);
  assign upd_max = (d > cur_max);
  assign nxt_min = upd_min ? d : cur_min;
  assign nxt_max = upd_max ? d : cur_max;

endmodule
`default_nettype wire

// File: rtl/min_max_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | min_max_stream_ctrl                                                  |
// | Accepts a burst of samples and reports its unsigned min and max.     |
// | Optional macro ARGMINMAX_EN adds min_idx/max_idx outputs.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module min_max_stream_ctrl
  import minmax_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              empty,
`ifdef ARGMINMAX_EN
  output logic [CNT_W-1:0]  min_idx,
  output logic [CNT_W-1:0]  max_idx,
`endif
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] max
);

  localparam logic [DATA_W-1:0] c_min_init = {DATA_W{MIN_INIT}};
  localparam logic [DATA_W-1:0] c_max_init = {DATA_W{MAX_INIT}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_min;
  logic [DATA_W-1:0]   r_max;
  logic                r_empty;
  logic [DATA_W-1:0]   w_nxt_min;
  logic [DATA_W-1:0]   w_nxt_max;
  logic                w_upd_min;
  logic                w_upd_max;
  logic                w_beat;
  logic                w_last;
  logic                w_accept;

  assign w_accept = (r_state == IDLE) && start;
  assign w_beat   = s_valid && s_ready;
  // Terminal beat is detected by compare, so the counter never reaches 2**CNT_W
  assign w_last   = (r_count == (r_len - CNT_W'(1)));

  minmax_cmp_core #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .d       (s_data),
    .cur_min (r_min),
    .cur_max (r_max),
    .nxt_min (w_nxt_min),
    .nxt_max (w_nxt_max),
    .upd_min (w_upd_min),
    .upd_max (w_upd_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_beat && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      RUN: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_count <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_empty <= 1'b0;
    end else if (w_accept) begin
      r_len   <= len;
      r_count <= '0;
      r_min   <= c_min_init;
      r_max   <= c_max_init;
      r_empty <= (len == '0);
    end else if (w_beat) begin
      r_count <= r_count + CNT_W'(1);
      r_min   <= w_nxt_min;
      r_max   <= w_nxt_max;
    end
  end

  assign min   = r_min;
  assign max   = r_max;
  assign empty = r_empty;

`ifdef ARGMINMAX_EN
  logic [CNT_W-1:0] r_min_idx;
  logic [CNT_W-1:0] r_max_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min_idx <= '0;
      r_max_idx <= '0;
    end else if (w_accept) begin
      r_min_idx <= '0;
      r_max_idx <= '0;
    end else if (w_beat) begin
      if (w_upd_min) r_min_idx <= r_count;
      if (w_upd_max) r_max_idx <= r_count;
    end
  end

  assign min_idx = r_min_idx;
  assign max_idx = r_max_idx;
`else
  logic w_unused_upd;
  assign w_unused_upd = w_upd_min ^ w_upd_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_min_max_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_min_max_stream_ctrl                                               |
// | Directed self-checking bench for min_max_stream_ctrl.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_min_max_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       busy;
  logic       done;
  logic       empty;
  logic [7:0] min;
  logic [7:0] max;
`ifdef ARGMINMAX_EN
  logic [7:0] min_idx;
  logic [7:0] max_idx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  min_max_stream_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .busy    (busy),
    .done    (done),
    .empty   (empty),
`ifdef ARGMINMAX_EN
    .min_idx (min_idx),
    .max_idx (max_idx),
`endif
    .min     (min),
    .max     (max)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL por_busy actual=%0d required=0", busy); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL por_s_ready actual=%0d required=0", s_ready); end
    n_checks++; if (min !== 8'd0 || max !== 8'd0) begin n_fail++; $display("FAIL por_minmax actual=%0d/%0d required=0/0", min, max); end
    rst = 1'b0;
    tick();
    // Abort a len=5 burst after 3 beats
    do_start(8'd5);
    beat(8'd1); beat(8'd2); beat(8'd3);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_run_s_ready actual=%0d required=1", s_ready); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_rst_ctrl actual=%0d%0d%0d required=000", busy, s_ready, done); end
    n_checks++; if (min !== 8'd0 || max !== 8'd0 || empty !== 1'b0) begin n_fail++; $display("FAIL async_rst_data actual=%0d/%0d/%0d required=0/0/0", min, max, empty); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle actual=%0d/%0d required=0/0", busy, done); end
    do_start(8'd2);
    beat(8'd10); beat(8'd20);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_restart_done actual=%0d required=1", done); end
    n_checks++; if (min !== 8'd10 || max !== 8'd20) begin n_fail++; $display("FAIL rst_restart_minmax actual=%0d/%0d required=10/20", min, max); end
    tick();
  endtask

  task automatic test_basic;
    do_start(8'd4);
    beat(8'd30); beat(8'd7); beat(8'd200);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done actual=%0d required=0", done); end
    beat(8'd7);
    n_checks++; if (done !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done actual=%0d%0d%0d required=110", done, busy, s_ready); end
    n_checks++; if (min !== 8'd7 || max !== 8'd200) begin n_fail++; $display("FAIL basic_minmax actual=%0d/%0d required=7/200", min, max); end
`ifdef ARGMINMAX_EN
    n_checks++; if (min_idx !== 8'd1 || max_idx !== 8'd2) begin n_fail++; $display("FAIL basic_idx actual=%0d/%0d required=1/2", min_idx, max_idx); end
`endif
    // Start during the DONE cycle must be dropped
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored actual=%0d/%0d required=0/0", done, busy); end
    tick();
    n_checks++; if (busy !== 1'b0 || min !== 8'd7 || max !== 8'd200) begin n_fail++; $display("FAIL basic_hold actual=%0d/%0d/%0d required=0/7/200", busy, min, max); end
  endtask

  task automatic test_gaps;
    logic [7:0] d [3];
    d[0] = 8'd5; d[1] = 8'd9; d[2] = 8'd1;
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      beat(d[i]);
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          n_checks++; if (s_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL gap_ready beat=%0d actual=%0d/%0d required=1/0", i, s_ready, done); end
          tick();
        end
      end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gaps_done actual=%0d required=1", done); end
    n_checks++; if (min !== 8'd1 || max !== 8'd9) begin n_fail++; $display("FAIL gaps_minmax actual=%0d/%0d required=1/9", min, max); end
`ifdef ARGMINMAX_EN
    n_checks++; if (min_idx !== 8'd2 || max_idx !== 8'd1) begin n_fail++; $display("FAIL gaps_idx actual=%0d/%0d required=2/1", min_idx, max_idx); end
`endif
    tick();
  endtask

  task automatic test_edges;
    do_start(8'd2);
    beat(8'd0); beat(8'd255);
    n_checks++; if (done !== 1'b1 || min !== 8'd0 || max !== 8'd255) begin n_fail++; $display("FAIL edge_0_255 actual=%0d/%0d/%0d required=1/0/255", done, min, max); end
`ifdef ARGMINMAX_EN
    n_checks++; if (min_idx !== 8'd0 || max_idx !== 8'd1) begin n_fail++; $display("FAIL edge_idx actual=%0d/%0d required=0/1", min_idx, max_idx); end
`endif
    tick();
    do_start(8'd1);
    beat(8'd42);
    n_checks++; if (done !== 1'b1 || min !== 8'd42 || max !== 8'd42) begin n_fail++; $display("FAIL single_42 actual=%0d/%0d/%0d required=1/42/42", done, min, max); end
    tick();
  endtask

  task automatic test_empty;
    do_start(8'd0);
    n_checks++; if (done !== 1'b1 || empty !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL empty_done actual=%0d%0d%0d required=110", done, empty, s_ready); end
    n_checks++; if (min !== 8'd255 || max !== 8'd0) begin n_fail++; $display("FAIL empty_minmax actual=%0d/%0d required=255/0", min, max); end
`ifdef ARGMINMAX_EN
    n_checks++; if (min_idx !== 8'd0 || max_idx !== 8'd0) begin n_fail++; $display("FAIL empty_idx actual=%0d/%0d required=0/0", min_idx, max_idx); end
`endif
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL empty_after actual=%0d%0d%0d required=001", done, busy, empty); end
  endtask

  task automatic test_busy_ignore;
    do_start(8'd3);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL empty_cleared actual=%0d required=0", empty); end
    beat(8'd100);
    start = 1'b1; len = 8'd9;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || s_ready !== 1'b1) begin n_fail++; $display("FAIL busy_run actual=%0d/%0d required=1/1", busy, s_ready); end
    beat(8'd50);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL busy_early_done actual=%0d required=0", done); end
    beat(8'd150);
    n_checks++; if (done !== 1'b1 || min !== 8'd50 || max !== 8'd150) begin n_fail++; $display("FAIL busy_result actual=%0d/%0d/%0d required=1/50/150", done, min, max); end
`ifdef ARGMINMAX_EN
    n_checks++; if (min_idx !== 8'd1 || max_idx !== 8'd2) begin n_fail++; $display("FAIL busy_idx actual=%0d/%0d required=1/2", min_idx, max_idx); end
`endif
    tick(); tick(); tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || min !== 8'd50 || max !== 8'd150) begin n_fail++; $display("FAIL busy_hold actual=%0d/%0d/%0d/%0d required=0/0/50/150", done, busy, min, max); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_edges();
    test_empty();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
